// File: rtl/shared_alu_sched.sv
// shared_alu_sched: round-robin arbiter in front of one shared multi-function ALU.
// Optional one-entry result reuse cache enabled by SHARED_ALU_DUP_REUSE_EN.
module shared_alu_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int MUL_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [3*NREQ-1:0]       req_op,
  input  logic [W*NREQ-1:0]       req_a,
  input  logic [W*NREQ-1:0]       req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [W-1:0]            rsp_data,
  output logic                    rsp_reused,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] rsp_id_q;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;
  logic [2:0]     op_q;
  logic [2:0]     sel_op;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   sel_a, sel_b;
  logic [W-1:0]   alu_res;
  logic [W-1:0]   data_q;
  logic [W-1:0]   hit_data;
  logic [2:0]     cnt_q;
  logic           reused_q;
  logic           hit;
  logic           exec_done;

  // Rotating-priority search starting just after the last served requester
  always_comb begin : p_grant
    int             idx;
    logic [IDW-1:0] cand;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx  = (int'(last_q) + k) % NREQ;
      cand = IDW'(idx);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign sel_op    = req_op[3*gnt_id +: 3];
  assign sel_a     = req_a[W*gnt_id +: W];
  assign sel_b     = req_b[W*gnt_id +: W];
  assign exec_done = (state_q == EXEC) && (cnt_q == 3'd1);

  // Shared ALU operating on the captured operands
  always_comb begin : p_alu
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_MUL:  alu_res = a_q * b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_CMP:  alu_res = {{(W-1){1'b0}}, a_q > b_q};
      default: alu_res = '0;
    endcase
  end

`ifdef SHARED_ALU_DUP_REUSE_EN
  logic         c_vld_q;
  logic [2:0]   c_op_q;
  logic [W-1:0] c_a_q, c_b_q, c_res_q;
  logic         comm;

  // Match the granted request against the last computed operation
  always_comb begin : p_hit
    comm = (sel_op == OP_ADD) || (sel_op == OP_MUL) ||
           (sel_op == OP_AND) || (sel_op == OP_OR) ||
           (sel_op == OP_XOR);
    hit  = c_vld_q && (sel_op == c_op_q) &&
           (((sel_a == c_a_q) && (sel_b == c_b_q)) ||
            (comm && (sel_a == c_b_q) && (sel_b == c_a_q)));
    hit_data = c_res_q;
  end

  // Remember every freshly computed result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_vld_q <= 1'b0;
      c_op_q  <= '0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_res_q <= '0;
    end else if (exec_done) begin
      c_vld_q <= 1'b1;
      c_op_q  <= op_q;
      c_a_q   <= a_q;
      c_b_q   <= b_q;
      c_res_q <= alu_res;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (gnt_vld)   state_d = hit ? RESP : EXEC;
      EXEC: if (exec_done) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // FSM outputs: single accept strobe only while idle
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && gnt_vld) req_ready[gnt_id] = 1'b1;
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
  end

  // Capture, execution countdown, response and pointer update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q   <= IDW'(NREQ-1);
      id_q     <= '0;
      rsp_id_q <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      reused_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && gnt_vld) begin
        op_q  <= sel_op;
        a_q   <= sel_a;
        b_q   <= sel_b;
        id_q  <= gnt_id;
        cnt_q <= (sel_op == OP_MUL) ? 3'(MUL_LAT) : 3'd1;
        if (hit) begin
          data_q   <= hit_data;
          rsp_id_q <= gnt_id;
          reused_q <= 1'b1;
        end
      end
      if (state_q == EXEC) begin
        if (cnt_q == 3'd1) begin
          data_q   <= alu_res;
          rsp_id_q <= id_q;
          reused_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
      end
      if ((state_q == RESP) && rsp_ready) last_q <= id_q;
    end
  end

  assign rsp_data   = data_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_reused = reused_q;

endmodule

// File: tb/tb_shared_alu_sched.sv
// tb_shared_alu_sched: vector table, hand sequences and random traffic
// against a transaction-level reference model of the shared ALU scheduler.
module tb_shared_alu_sched;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_reused, busy;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;

  int checks   = 0;
  int failures = 0;

  // model state: round-robin pointer and one-entry reuse cache
  int m_last;
  bit mc_vld;
  int mc_op, mc_a, mc_b;

  always #5 clk = ~clk;

  shared_alu_sched #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_reused(rsp_reused), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      0: return (a + b) & 255;
      1: return (a - b) & 255;
      2: return (a * b) & 255;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return (a > b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit mdl_hit(input int op, input int a, input int b);
`ifdef SHARED_ALU_DUP_REUSE_EN
    if (!mc_vld || op != mc_op) return 1'b0;
    if (a == mc_a && b == mc_b) return 1'b1;
    if ((op == 0 || op == 2 || op == 3 || op == 4 || op == 5) &&
        a == mc_b && b == mc_a) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // invariant: accept strobe at most one-hot and never while busy
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("req_ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      if (busy === 1'b1) chk("req_ready_busy", 32'(req_ready), 32'd0);
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_reused", 32'(rsp_reused), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_last = NREQ - 1;
    mc_vld = 1'b0;
  endtask

  // one full transaction; exp_d / exp_ru < 0 means "take from model"
  task automatic txn(input logic [3:0] mask, input logic [11:0] ops,
                     input logic [31:0] as, input logic [31:0] bs,
                     input int exp_d, input int exp_ru, input bit bp);
    int g, op, a, b, n, lat, exp, ru, idx;
    bit hit, seen, done;
    g = -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (m_last + k) % NREQ;
      if (g < 0 && mask[idx]) g = idx;
    end
    op  = int'(ops[3*g +: 3]);
    a   = int'(as[8*g +: 8]);
    b   = int'(bs[8*g +: 8]);
    hit = mdl_hit(op, a, b);
    lat = hit ? 1 : ((op == 2) ? 1 + MUL_LAT : 2);
    exp = (exp_d >= 0) ? exp_d : ref_alu(op, a, b);
    ru  = (exp_ru >= 0) ? exp_ru : int'(hit);
    req_valid = mask;
    req_op    = ops;
    req_a     = as;
    req_b     = bs;
    rsp_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(1 << g));
    chk("busy_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1 req_valid = '0;
    n = 0; seen = 0; done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        if (!seen) begin
          chk("latency", 32'(n), 32'(lat));
          seen = 1;
        end
        chk("rsp_data", 32'(rsp_data), 32'(exp));
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_reused", 32'(rsp_reused), 32'(ru));
        if (rsp_ready) done = 1;
      end
      @(posedge clk);
      #1;
      if (bp) rsp_ready = 1'($urandom_range(0, 1));
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    if (!hit) begin
      mc_vld = 1'b1;
      mc_op  = op;
      mc_a   = a;
      mc_b   = b;
    end
    m_last = g;
  endtask

  task automatic one(input int id, input int op, input int a, input int b,
                     input int exp, input int ru);
    logic [11:0] ops;
    logic [31:0] as, bs;
    ops = '0; as = '0; bs = '0;
    ops[3*id +: 3] = 3'(op);
    as[8*id +: 8]  = 8'(a);
    bs[8*id +: 8]  = 8'(b);
    txn(4'(1 << id), ops, as, bs, exp, ru, 1'b0);
  endtask

  typedef struct {
    int id;
    int op;
    int a;
    int b;
    int exp;
  } vec_t;

  vec_t tbl[12];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n, expg, bad;
    req_op = '0; req_a = '0; req_b = '0;
    req_valid = '0; rsp_ready = 1'b0; rst_n = 1'b0;

    tbl[0]  = '{0, 0, 200, 100, 44};
    tbl[1]  = '{2, 2, 15, 17, 255};
    tbl[2]  = '{1, 1, 3, 5, 254};
    tbl[3]  = '{3, 3, 'hF0, 'h3C, 'h30};
    tbl[4]  = '{0, 4, 'hF0, 'h0F, 'hFF};
    tbl[5]  = '{1, 5, 'hAA, 'hFF, 'h55};
    tbl[6]  = '{2, 6, 9, 8, 1};
    tbl[7]  = '{3, 6, 8, 9, 0};
    tbl[8]  = '{0, 6, 5, 5, 0};
    tbl[9]  = '{1, 7, 12, 34, 0};
    tbl[10] = '{2, 2, 16, 16, 0};
    tbl[11] = '{3, 1, 0, 1, 255};

    do_reset();
    for (int i = 0; i < 12; i++)
      one(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, -1);

    // round-robin with all requesters continuously valid
    do_reset();
    req_op = '0;
    req_a  = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b  = {8'd40, 8'd30, 8'd20, 8'd10};
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int gi = 0; gi < 5; gi++) begin
      expg = (m_last + 1) % NREQ;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (req_ready == 4'd0 && n < 20);
      chk("rr_grant", 32'(req_ready), 32'(1 << expg));
      m_last = expg;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    repeat (6) @(posedge clk);

    // backpressure: response held while another requester waits
    do_reset();
    rsp_ready = 1'b0;
    req_op = '0;
    req_op[5:3] = 3'b101;
    req_a = {8'd0, 8'd1, 8'h5A, 8'd0};
    req_b = {8'd0, 8'd2, 8'h0F, 8'd0};
    req_valid = 4'b0110;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'd2);
    @(posedge clk);
    #1 req_valid = 4'b0100;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data", 32'(rsp_data), 32'h55);
      chk("bp_hold_id", 32'(rsp_id), 32'd1);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'd4);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);

    // reset asserted while a multiply is executing
    do_reset();
    rsp_ready = 1'b1;
    req_op = 12'b000_010_000_000;
    req_a  = {8'd0, 8'd15, 8'd0, 8'd0};
    req_b  = {8'd0, 8'd17, 8'd0, 8'd0};
    req_valid = 4'b0100;
    @(negedge clk);
    chk("mr_grant", 32'(req_ready), 32'd4);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_busy_exec", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    chk("mr_no_rsp", 32'(bad), 32'd0);
    m_last = NREQ - 1;
    mc_vld = 1'b0;

    // randomized traffic against the model
    do_reset();
    for (int t = 0; t < 200; t++) begin
      logic [31:0] as, bs;
      for (int j = 0; j < 4; j++) begin
        as[8*j +: 8] = $urandom_range(0, 1) ? 8'($urandom_range(0, 3))
                                            : 8'($urandom);
        bs[8*j +: 8] = $urandom_range(0, 1) ? 8'($urandom_range(0, 3))
                                            : 8'($urandom);
      end
      txn(4'($urandom_range(1, 15)), 12'($urandom), as, bs, -1, -1, 1'b1);
    end

`ifdef SHARED_ALU_DUP_REUSE_EN
    do_reset();
    one(1, 0, 7, 9, 16, 0);
    one(3, 0, 9, 7, 16, 1);
    one(0, 1, 7, 9, 254, 0);
    one(2, 1, 9, 7, 2, 0);
    one(1, 1, 9, 7, 2, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
